// File: rtl/mux2_stream_arb.sv
// rtl/mux2_stream_arb.sv - round-robin burst-limited 2:1 stream arbiter with registered output stage
// Optional packet lock (grant held until last beat): define MUX2_STREAM_ARB_LOCK_EN.
module mux2_stream_arb #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             sel,
    output logic             z_valid,
    output logic [WIDTH-1:0] z_data,
    input  logic             z_ready
`ifdef MUX2_STREAM_ARB_LOCK_EN
    ,
    input  logic             x_last,
    input  logic             y_last,
    output logic             z_last
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_X = 2'd1,
        GNT_Y = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state, state_nxt;
    logic       sel_nxt;
    logic       last_grant, last_grant_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       space;
    logic       x_xfer, y_xfer;
    logic       x_burst_end, y_burst_end;
    logic       x_exit, y_exit;

    assign space   = !z_valid || z_ready;
    // Readies are held low during reset so no beat is lost to a discarded stage.
    assign x_ready = !rst && (state == GNT_X) && space;
    assign y_ready = !rst && (state == GNT_Y) && space;
    assign x_xfer  = x_valid && x_ready;
    assign y_xfer  = y_valid && y_ready;

`ifdef MUX2_STREAM_ARB_LOCK_EN
    // Packet lock: the burst counter stays parked at zero.
    assign x_burst_end = 1'b1;
    assign y_burst_end = 1'b1;
    assign x_exit      = x_xfer && x_last;
    assign y_exit      = y_xfer && y_last;
`else
    assign x_burst_end = x_xfer && (cnt == BURST_LAST);
    assign y_burst_end = y_xfer && (cnt == BURST_LAST);
    assign x_exit      = !x_valid || (x_burst_end && y_valid);
    assign y_exit      = !y_valid || (y_burst_end && x_valid);
`endif

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        case (state)
            IDLE: begin
                if (x_valid && (!y_valid || last_grant)) begin
                    state_nxt = GNT_X;
                    sel_nxt   = 1'b0;
                end else if (y_valid) begin
                    state_nxt = GNT_Y;
                    sel_nxt   = 1'b1;
                end
            end
            GNT_X: begin
                if (x_exit) begin
                    state_nxt      = y_valid ? GNT_Y : IDLE;
                    sel_nxt        = y_valid ? 1'b1 : sel;
                    cnt_nxt        = 8'd0;
                    last_grant_nxt = 1'b0;
                end else if (x_xfer) begin
                    cnt_nxt = x_burst_end ? 8'd0 : cnt + 8'd1;
                end
            end
            GNT_Y: begin
                if (y_exit) begin
                    state_nxt      = x_valid ? GNT_X : IDLE;
                    sel_nxt        = x_valid ? 1'b0 : sel;
                    cnt_nxt        = 8'd0;
                    last_grant_nxt = 1'b1;
                end else if (y_xfer) begin
                    cnt_nxt = y_burst_end ? 8'd0 : cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 8'd0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_valid <= 1'b0;
            z_data  <= '0;
`ifdef MUX2_STREAM_ARB_LOCK_EN
            z_last  <= 1'b0;
`endif
        end else if (x_xfer) begin
            z_valid <= 1'b1;
            z_data  <= x_data;
`ifdef MUX2_STREAM_ARB_LOCK_EN
            z_last  <= x_last;
`endif
        end else if (y_xfer) begin
            z_valid <= 1'b1;
            z_data  <= y_data;
`ifdef MUX2_STREAM_ARB_LOCK_EN
            z_last  <= y_last;
`endif
        end else if (z_ready) begin
            z_valid <= 1'b0;
        end
    end

endmodule
